// File: rtl/spio_counter_sweeper_if.sv
// Stream and counter-bank access bundle for spio_counter_sweeper.
// The sweeper is master of both: it drives ctr_addr and the out_* word, and samples ctr_data/out_rdy.
interface spio_counter_sweeper_if #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] ctr_addr;
    logic [DATA_BITS-1:0] ctr_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [ADDR_BITS-1:0] out_addr;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_last;

    modport master (
        output ctr_addr, out_vld, out_addr, out_data, out_last,
        input  ctr_data, out_rdy
    );
    modport slave (
        input  ctr_addr, out_vld, out_addr, out_data, out_last,
        output ctr_data, out_rdy
    );
endinterface

// File: rtl/spio_counter_sweeper.sv
// Walks the counter bank 0..NUM_CTRS-1 and streams one {addr,data} word per counter.
// Optional SPIO_CTR_SWEEP_DELTA_EN: emit the change since the previous sweep instead of raw values.
module spio_counter_sweeper #(
    parameter int ADDR_BITS     = 6,
    parameter int DATA_BITS     = 32,
    parameter int NUM_CTRS      = 64,
    parameter int PERIOD_CYCLES = 1000000
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    input  logic                          enable_in,
    input  logic                          trigger_in,
    spio_counter_sweeper_if.master        bus,
    output logic                          busy_out,
    output logic                          overrun_out,
    output logic [15:0]                   sweep_cnt_out
);
    localparam int TW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0]        TMAX      = TW'(PERIOD_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CTRS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]           state;
    logic [TW-1:0]        timer;
    logic                 tick;
    logic                 start;
    logic [DATA_BITS-1:0] rd_data;

    assign tick  = enable_in && (timer == TMAX);
    assign start = (state == ST_IDLE) && enable_in && (tick || trigger_in);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN)        timer <= '0;
        else if (!enable_in) timer <= '0;
        else if (tick)       timer <= '0;
        else                 timer <= timer + TW'(1);
    end

`ifdef SPIO_CTR_SWEEP_DELTA_EN
    logic [DATA_BITS-1:0] prev [NUM_CTRS];

    // Store is refreshed when the value is read, so a stalled word does not delay it.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            for (int i = 0; i < NUM_CTRS; i++) prev[i] <= '0;
        end else if (state == ST_READ) begin
            prev[bus.ctr_addr] <= bus.ctr_data;
        end
    end

    assign rd_data = bus.ctr_data - prev[bus.ctr_addr];
`else
    assign rd_data = bus.ctr_data;
`endif

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state         <= ST_IDLE;
            bus.ctr_addr  <= '0;
            bus.out_vld   <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            busy_out      <= 1'b0;
            overrun_out   <= 1'b0;
            sweep_cnt_out <= '0;
        end else begin
            // A tick that cannot start a sweep is lost; remember that it happened.
            if (tick && state != ST_IDLE) overrun_out <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.ctr_addr <= '0;
                        busy_out     <= 1'b1;
                        state        <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.out_data <= rd_data;
                    bus.out_addr <= bus.ctr_addr;
                    bus.out_vld  <= 1'b1;
                    bus.out_last <= (bus.ctr_addr == LAST_ADDR);
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.out_rdy) begin
                        bus.out_vld <= 1'b0;
                        if (bus.out_last) begin
                            busy_out      <= 1'b0;
                            sweep_cnt_out <= sweep_cnt_out + 16'd1;
                            state         <= ST_IDLE;
                        end else begin
                            bus.ctr_addr <= bus.ctr_addr + ADDR_BITS'(1);
                            state        <= ST_READ;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
